// File: rtl/cmd_fifo_arbiter_if.sv
// Requester-side and FIFO-side signal bundle for cmd_fifo_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface cmd_fifo_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int CMD_WIDTH  = 17,
   parameter int DATA_WIDTH = 8
);
   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd;
   logic [NUM_REQ-1:0]           req_ready;
   logic [NUM_REQ-1:0]           rsp_valid;
   logic [DATA_WIDTH-1:0]        rsp_data;
   logic                         cmd_fifo_wr_en;
   logic [CMD_WIDTH-1:0]         cmd_fifo_data;
   logic                         cmd_fifo_full;
   logic                         resp_fifo_rd_en;
   logic [DATA_WIDTH-1:0]        resp_fifo_data;
   logic                         resp_fifo_empty;

   modport slave (
      input  req_valid, req_cmd, cmd_fifo_full, resp_fifo_data, resp_fifo_empty,
      output req_ready, rsp_valid, rsp_data, cmd_fifo_wr_en, cmd_fifo_data, resp_fifo_rd_en
   );

   modport master (
      output req_valid, req_cmd, cmd_fifo_full, resp_fifo_data, resp_fifo_empty,
      input  req_ready, rsp_valid, rsp_data, cmd_fifo_wr_en, cmd_fifo_data, resp_fifo_rd_en
   );
endinterface

// File: rtl/cmd_fifo_arbiter.sv
// Round-robin arbiter sharing one command FIFO among NUM_REQ requesters; read responses
// are routed back in issue order using a circular queue of requester IDs.
module cmd_fifo_arbiter #(
   parameter int NUM_REQ         = 4,
   parameter int CMD_WIDTH       = 17,
   parameter int DATA_WIDTH      = 8,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                               i_clk,
   input  logic                               i_rst_n,
   cmd_fifo_arbiter_if.slave                  bus,
   output logic [$clog2(MAX_OUTSTANDING):0]   o_outstanding,
   output logic                               o_err_orphan
);
   localparam int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int PTR_W    = $clog2(MAX_OUTSTANDING);
   localparam int CNT_W    = PTR_W + 1;

   typedef enum logic {R_IDLE, R_CAPT} resp_state_t;

   resp_state_t            r_state;
   resp_state_t            w_state_next;
   logic [ID_WIDTH-1:0]    r_rr_ptr;
   logic [ID_WIDTH-1:0]    r_tag_mem [MAX_OUTSTANDING];
   logic [PTR_W-1:0]       r_tag_wr_ptr;
   logic [PTR_W-1:0]       r_tag_rd_ptr;
   logic [CNT_W-1:0]       r_outstanding;
   logic [NUM_REQ-1:0]     r_rsp_valid;
   logic [DATA_WIDTH-1:0]  r_rsp_data;
   logic                   r_err_orphan;

   logic [CMD_WIDTH-1:0]   w_cmd [NUM_REQ];
   logic [NUM_REQ-1:0]     w_eligible;
   logic [NUM_REQ-1:0]     w_grant;
   logic [ID_WIDTH-1:0]    w_gnt_idx;
   logic                   w_gnt_found;
   logic [ID_WIDTH:0]      w_sum;
   logic                   w_issue_read;
   logic                   w_tag_pop;
   logic [CNT_W-1:0]       w_cnt_after_pop;
   logic                   w_read_ok;
   logic                   w_rd_en;
   logic [ID_WIDTH-1:0]    w_tag_head;
   logic [NUM_REQ-1:0]     w_head_onehot;

   // A pop in the same cycle frees a slot, so a full queue can still accept a read.
   assign w_tag_pop       = (r_state == R_CAPT) && (r_outstanding != '0);
   assign w_cnt_after_pop = r_outstanding - CNT_W'(w_tag_pop);
   assign w_read_ok       = w_cnt_after_pop < CNT_W'(MAX_OUTSTANDING);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign w_cmd[gi]      = bus.req_cmd[gi*CMD_WIDTH +: CMD_WIDTH];
         assign w_eligible[gi] = bus.req_valid[gi] & (w_cmd[gi][CMD_WIDTH-1] | w_read_ok);
      end
   endgenerate

   always_comb begin
      w_grant     = '0;
      w_gnt_idx   = '0;
      w_gnt_found = 1'b0;
      w_sum       = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_sum = {1'b0, r_rr_ptr} + (ID_WIDTH+1)'(k);
         if (w_sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
            w_sum = w_sum - (ID_WIDTH+1)'(NUM_REQ);
         end
         if (!w_gnt_found && w_eligible[w_sum[ID_WIDTH-1:0]]) begin
            w_gnt_found = 1'b1;
            w_gnt_idx   = w_sum[ID_WIDTH-1:0];
         end
      end
      if (!i_rst_n || bus.cmd_fifo_full) begin
         w_gnt_found = 1'b0;
      end
      if (w_gnt_found) begin
         w_grant[w_gnt_idx] = 1'b1;
      end
   end

   assign w_issue_read = w_gnt_found & ~w_cmd[w_gnt_idx][CMD_WIDTH-1];

   always_comb begin
      w_state_next = r_state;
      w_rd_en      = 1'b0;
      case (r_state)
         R_IDLE: begin
            if (!bus.resp_fifo_empty) begin
               w_rd_en      = 1'b1;
               w_state_next = R_CAPT;
            end
         end
         R_CAPT:  w_state_next = R_IDLE;
         default: w_state_next = R_IDLE;
      endcase
   end

   assign w_tag_head = r_tag_mem[r_tag_rd_ptr];

   always_comb begin
      w_head_onehot             = '0;
      w_head_onehot[w_tag_head] = 1'b1;
   end

   // Tag storage carries no reset; the pointers and count define what is valid.
   always_ff @(posedge i_clk) begin
      if (w_issue_read) begin
         r_tag_mem[r_tag_wr_ptr] <= w_gnt_idx;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= R_IDLE;
         r_rr_ptr      <= '0;
         r_tag_wr_ptr  <= '0;
         r_tag_rd_ptr  <= '0;
         r_outstanding <= '0;
         r_rsp_valid   <= '0;
         r_rsp_data    <= '0;
         r_err_orphan  <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_outstanding <= r_outstanding + CNT_W'(w_issue_read) - CNT_W'(w_tag_pop);
         r_rsp_valid   <= '0;
         if (w_gnt_found) begin
            r_rr_ptr <= w_gnt_idx;
         end
         if (w_issue_read) begin
            r_tag_wr_ptr <= r_tag_wr_ptr + PTR_W'(1);
         end
         if (w_tag_pop) begin
            r_tag_rd_ptr <= r_tag_rd_ptr + PTR_W'(1);
         end
         // A response with no recorded owner is dropped and flagged.
         if (r_state == R_CAPT) begin
            if (w_tag_pop) begin
               r_rsp_data  <= bus.resp_fifo_data;
               r_rsp_valid <= w_head_onehot;
            end else begin
               r_err_orphan <= 1'b1;
            end
         end
      end
   end

   assign bus.req_ready       = w_grant;
   assign bus.cmd_fifo_wr_en  = w_gnt_found;
   assign bus.cmd_fifo_data   = w_gnt_found ? w_cmd[w_gnt_idx] : '0;
   assign bus.resp_fifo_rd_en = w_rd_en;
   assign bus.rsp_valid       = r_rsp_valid;
   assign bus.rsp_data        = r_rsp_data;
   assign o_outstanding       = r_outstanding;
   assign o_err_orphan        = r_err_orphan;
endmodule
